// File: rtl/countdown_20sys_if.sv
// Control/status bundle for the 20-system down-counter.
//   en, load, din, start, abort : commands from the controller (master -> slave)
//   cnt, busy, done, bout       : counter status (slave -> master)
// clk and rst_n are plain ports on the counter and are not part of this bundle.
interface countdown_20sys_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
  logic             bout;

  modport master (
    output en, load, din, start, abort,
    input  cnt, busy, done, bout
  );

  modport slave (
    input  en, load, din, start, abort,
    output cnt, busy, done, bout
  );
endinterface

// File: rtl/countdown_20sys.sv
// Loadable down-counter/timer with range 0..MODULUS-1.
// A load value is saturated to MODULUS-1 and captured into both the count and the
// reload register. START begins the countdown; each EN in RUN decrements once.
// The 1->0 step is the terminal event: bout pulses for one cycle, and the block
// either parks in DONE or, with AUTO_RELOAD=1, reloads and keeps running.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low
//   bus   : countdown_20sys_if.slave (en, load, din, start, abort in;
//           cnt, busy, done, bout out)
module countdown_20sys #(
  parameter int MODULUS     = 20,
  parameter int WIDTH       = 5,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  countdown_20sys_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One extra bit so the saturation compare still works when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rld_q,   rld_d;
  logic             bout_q,  bout_d;
  logic [WIDTH-1:0] din_sat;

  assign din_sat = ({1'b0, bus.din} >= MOD_EXT) ? MAX_CNT : bus.din;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    bout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // LOAD has priority over START in the same cycle.
        if (bus.load) begin
          cnt_d = din_sat;
          rld_d = din_sat;
        end else if (bus.start) begin
          // Starting from zero has nothing to count: go straight to DONE, no pulse.
          state_d = (cnt_q != ZERO) ? S_RUN : S_DONE;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.en) begin
          if (cnt_q == ONE) begin
            bout_d = 1'b1;
            if (AUTO_RELOAD) begin
              // Reload in the same edge so consecutive periods have no gap.
              cnt_d = rld_q;
            end else begin
              cnt_d   = ZERO;
              state_d = S_DONE;
            end
          end else if (cnt_q != ZERO) begin
            cnt_d = cnt_q - ONE;
          end
        end
      end

      S_DONE: begin
        if (bus.load) begin
          cnt_d   = din_sat;
          rld_d   = din_sat;
          state_d = S_IDLE;
        end else if (bus.start) begin
          cnt_d = rld_q;
          if (rld_q != ZERO) state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= ZERO;
      rld_q   <= ZERO;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.bout = bout_q;

endmodule
